// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-PC sequencer.
// Optional misaligned-redirect trapping is enabled by defining PC_SEQ_ALIGN_CHECK_EN.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT,
    ST_HALT
  } seq_state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
  localparam logic [31:0] DEFAULT_HALT_PC  = 32'd248;
  localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0000_0100;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Signal bundle between the PC sequencer and its neighbours (hazard unit, EX, imem, IF).
// The trap/bad_pc signals exist only when PC_SEQ_ALIGN_CHECK_EN is defined.
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_ready_i;
  logic [31:0] pc_o;
  logic        fetch_valid_o;
  logic        flush_o;
  logic        halted_o;
`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic        trap_o;
  logic [31:0] bad_pc_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_ready_i,
    output pc_o, fetch_valid_o, flush_o, halted_o, trap_o, bad_pc_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_ready_i,
    input  pc_o, fetch_valid_o, flush_o, halted_o, trap_o, bad_pc_o
  );
`else
  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_ready_i,
    output pc_o, fetch_valid_o, flush_o, halted_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_ready_i,
    input  pc_o, fetch_valid_o, flush_o, halted_o
  );
`endif

endinterface

// File: rtl/pc_redirect_buffer.sv
// Holds one redirect target that arrived while a fetch was still outstanding.
// A new load overwrites the stored target; release clears the valid flag.
module pc_redirect_buffer
  import pc_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        start_i_n,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        release_i,
  output logic        valid_o,
  output logic [31:0] pc_o
);

  always_ff @(posedge clk_i) begin
    if (!start_i_n) begin
      valid_o <= 1'b0;
      pc_o    <= 32'd0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      pc_o    <= load_pc_i;
    end else if (release_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC controller: sequential advance, EX redirects, stall hold, address-stable waits, halt.
// Define PC_SEQ_ALIGN_CHECK_EN to trap misaligned redirect targets instead of aligning them.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] HALT_PC  = DEFAULT_HALT_PC
`ifdef PC_SEQ_ALIGN_CHECK_EN
  ,
  parameter logic [31:0] TRAP_PC  = DEFAULT_TRAP_PC
`endif
)
(
  input  logic           clk_i,
  input  logic           start_i_n,
  pc_sequencer_if.master bus
);

  seq_state_e  state;
  logic [31:0] pc_q;
  logic        fetch_valid_q;
  logic        halted_q;

  logic        active;
  logic        outstanding;
  logic        accept;
  logic        take_redirect;
  logic        redirect_now;
  logic        release_now;
  logic        load_pc;
  logic        halt_now;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic [31:0] target;
  logic [31:0] load_value;

`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic        target_bad;
  logic        trap_q;
  logic [31:0] bad_pc_q;
`endif

  // A redirect always wins over a pending release; both reload the PC from a target.
  always_comb begin
    active        = (state != ST_HALT);
    outstanding   = fetch_valid_q & ~bus.imem_ready_i;
    accept        = fetch_valid_q & bus.imem_ready_i & ~bus.stall_i;
    take_redirect = active & bus.redirect_i;
    redirect_now  = take_redirect & ~outstanding;
    release_now   = ~take_redirect & accept & pend_valid;
    load_pc       = redirect_now | release_now;
    halt_now      = accept & ~take_redirect & ~pend_valid & (pc_q == HALT_PC);
    target        = take_redirect ? bus.redirect_pc_i : pend_pc;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    target_bad    = (target[1:0] != 2'b00);
    load_value    = target_bad ? TRAP_PC : target;
`else
    load_value    = word_align(target);
`endif
  end

  pc_redirect_buffer u_redirect_buffer (
    .clk_i     (clk_i),
    .start_i_n (start_i_n),
    .load_i    (take_redirect & outstanding),
    .load_pc_i (bus.redirect_pc_i),
    .release_i (load_pc),
    .valid_o   (pend_valid),
    .pc_o      (pend_pc)
  );

  always_ff @(posedge clk_i) begin
    if (!start_i_n) begin
      state         <= ST_IDLE;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      trap_q        <= 1'b0;
      bad_pc_q      <= 32'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          state         <= ST_RUN;
          fetch_valid_q <= 1'b1;
        end
        ST_RUN, ST_WAIT: begin
          if (halt_now) begin
            state         <= ST_HALT;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else if (!bus.imem_ready_i) begin
            state <= ST_WAIT;
          end else begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_HALT;
      endcase

      // Halting accept keeps the PC parked on the halt address.
      if (load_pc) begin
        pc_q <= load_value;
      end else if (accept && !halt_now) begin
        pc_q <= pc_q + PC_STEP;
      end

`ifdef PC_SEQ_ALIGN_CHECK_EN
      trap_q <= load_pc & target_bad;
      if (load_pc && target_bad) begin
        bad_pc_q <= target;
      end
`endif
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.fetch_valid_o = fetch_valid_q;
  assign bus.halted_o      = halted_q;
  assign bus.flush_o       = start_i_n & (take_redirect | (accept & pend_valid));
`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign bus.trap_o        = trap_q;
  assign bus.bad_pc_o      = bad_pc_q;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-PC controller for the RV32IM pipeline: owns the program counter, advances it by 4 per accepted fetch, and applies branch/jump redirects from EX. It holds the PC on hazard stalls and keeps the instruction-memory address stable while a fetch is unaccepted. It also stops fetch permanently at the halt address. It sits between the hazard unit, the EX branch resolver and instruction memory, and drives the IF stage.

## Interface
- RESET_PC, 32'd0, PC value after reset
- HALT_PC, 32'd248, end-of-program address; fetch stops after it is accepted
- TRAP_PC, 32'h0000_0100, misaligned-redirect target (`PC_SEQ_ALIGN_CHECK_EN` only)

- clk_i  in  1  single clock, rising edge
- start_i_n  in  1  reset, synchronous, active-low
- stall_i  in  1  hazard-unit PC hold
- redirect_i  in  1  taken branch/jump from EX
- redirect_pc_i  in  32  redirect target
- imem_ready_i  in  1  instruction memory accepts address this cycle
- pc_o  out  32  fetch address
- fetch_valid_o  out  1  fetch request
- flush_o  out  1  kill IF/ID contents this cycle (combinational)
- halted_o  out  1  sequencer halted
- trap_o  out  1  misaligned redirect pulse (macro only)
- bad_pc_o  out  32  offending target (macro only)

## Operation
- States: IDLE, RUN, WAIT, HALT.
- Reset (start_i_n=0 at the edge) gives: pc_o=RESET_PC, fetch_valid_o=0, halted_o=0, trap_o=0, bad_pc_o=0, pending cleared, state IDLE. flush_o=0 while start_i_n=0.
- IDLE → RUN unconditionally on the next edge.
- fetch_valid_o=1 in RUN and WAIT, 0 in IDLE and HALT.
- accept = fetch_valid_o & imem_ready_i & !stall_i.
- outstanding = fetch_valid_o & !imem_ready_i. While outstanding, pc_o must not change (address-stable rule).
- Next-PC priority, highest first:
  1. reset
  2. HALT (pc_o is held)
  3. redirect
  4. pending release
  5. stall
  6. not ready
  7. sequential
- Redirect when not outstanding: pc_o ← redirect_pc_i and flush_o=1 that cycle. This applies even if stall_i=1.
- Redirect while outstanding: the target is latched into the pending register, pc_o is held, and flush_o=1. A later redirect before release overwrites pending.
- Pending release: on the first accept with pending valid, pc_o ← pending_pc, pending is cleared, and flush_o=1, because the accepted fetch was wrong-path.
- Sequential: on accept, pc_o ← pc_o + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- If imem_ready_i=0, the state goes RUN→WAIT; when ready returns, WAIT→RUN.
- stall_i=1: pc_o is held and fetch_valid_o stays 1.
- Halt: an accept with pc_o==HALT_PC, no pending and no redirect moves the state to HALT. In HALT, halted_o=1 and pc_o=HALT_PC. redirect_i and stall_i are ignored and flush_o=0. Only reset leaves HALT.
- A redirect in the same cycle as a HALT_PC accept wins, and the halt is not entered.

## Timing
- Redirect sampled at edge N: pc_o shows the target after edge N (one-cycle latency).
- flush_o is asserted in the same cycle as the redirect or pending release.
- Sequential advance takes 1 cycle per accept, so back-to-back accepts give +4 every cycle.
- The first fetch_valid_o is seen in the 2nd cycle after reset is released.
- halted_o rises after the edge that accepts HALT_PC.

## Configuration
- `PC_SEQ_ALIGN_CHECK_EN` defined:
  - A redirect (or pending release) whose target has [1:0]≠0 loads pc_o ← TRAP_PC instead of the target.
  - trap_o is a registered 1-cycle pulse, and bad_pc_o captures the target.
- `PC_SEQ_ALIGN_CHECK_EN` undefined:
  - Target[1:0] is forced to 2'b00.
  - trap_o and bad_pc_o ports are absent.

## Structure
- Package pc_seq_pkg holds:
  - the state enum
  - PC_STEP=4
  - default RESET_PC/HALT_PC/TRAP_PC constants
- Sub-module pc_redirect_buffer: the pending valid/target register with load, overwrite and release.

## Test plan
- Reset release, imem_ready_i=1, no events → pc_o sequence 0,4,8,…; fetch_valid_o first high in cycle 2.
- stall_i high 3 cycles at pc_o=0x10 → pc_o holds 0x10; it resumes to 0x14 the cycle after stall_i drops.
- redirect_i to 0x40 while not outstanding → flush_o=1 that cycle, pc_o=0x40 next cycle, then 0x44.
- imem_ready_i=0 at pc_o=0x20, redirect to 0x80, then ready=1 → pc_o stays 0x20 until accept, then 0x80; flush_o pulses at both the redirect and the release.
- Run to 248 → halted_o=1, pc_o=248, fetch_valid_o=0; a redirect to 0x0 is ignored; start_i_n=0 → pc_o=0.
- With the macro, redirect to 0x42 → pc_o=0x100, trap_o 1-cycle pulse, bad_pc_o=0x42. Without the macro → pc_o=0x40.
